// File: rtl/bnk_sched.sv
// bnk_sched: shares one bank command bus between the CPU port and the line-fill port.
// Optional macro BNK_SCHED_STATS_EN adds a saturating CPU stall counter output.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   cpu_req/we/addr/be/wdata      CPU single-word access request
//   cpu_gnt                       comb grant, transfer on cpu_req & cpu_gnt
//   fill_req/fill_addr            line-fill burst request, base word address
//   fill_gnt                      comb grant, burst accepted on fill_req & fill_gnt
//   fill_valid/fill_wdata         fill beat stream
//   fill_ready                    comb, beat consumed on fill_valid & fill_ready
//   fill_done                     registered pulse with the last beat on the bus
//   bank_sel/we/row/be/wdata      registered bank command bus
//   stall_cnt                     (BNK_SCHED_STATS_EN only) CPU stall cycles, saturating
//   busy                          registered, high while a fill burst is active
module bnk_sched #(
    parameter int NBANKS     = 4,
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int FILL_BEATS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [AW-1:0]                 cpu_addr,
    input  logic [3:0]                    cpu_be,
    input  logic [DW-1:0]                 cpu_wdata,
    output logic                          cpu_gnt,
    input  logic                          fill_req,
    input  logic [AW-1:0]                 fill_addr,
    output logic                          fill_gnt,
    input  logic                          fill_valid,
    input  logic [DW-1:0]                 fill_wdata,
    output logic                          fill_ready,
    output logic                          fill_done,
    output logic [NBANKS-1:0]             bank_sel,
    output logic                          bank_we,
    output logic [AW-$clog2(NBANKS)-1:0]  bank_row,
    output logic [3:0]                    bank_be,
    output logic [DW-1:0]                 bank_wdata,
`ifdef BNK_SCHED_STATS_EN
    output logic [15:0]                   stall_cnt,
`endif
    output logic                          busy
);

    localparam int BW  = $clog2(NBANKS);
    localparam int FBW = $clog2(FILL_BEATS);
    localparam int CW  = (FBW < 1) ? 1 : FBW;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // 1: a contested IDLE cycle grants fill, 0: grants CPU
    logic            rr_fill;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   base;

    logic            contest;
    logic            cpu_xfer;
    logic            fill_acc;
    logic            beat;
    logic            last_beat;
    logic [AW-1:0]   beat_addr;

    function automatic logic [NBANKS-1:0] onehot(input logic [BW-1:0] idx);
        logic [NBANKS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign contest   = (state == IDLE) & cpu_req & fill_req;
    assign cpu_xfer  = cpu_req & cpu_gnt;
    assign fill_acc  = fill_req & fill_gnt;
    assign beat      = fill_valid & fill_ready;
    assign last_beat = (cnt == CW'(FILL_BEATS - 1));
    // Base is line aligned, so OR-ing the beat index walks the banks in order
    assign beat_addr = base | AW'(cnt);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fill_acc) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (beat && last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        cpu_gnt    = 1'b0;
        fill_gnt   = 1'b0;
        fill_ready = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_gnt  = cpu_req & (~fill_req | ~rr_fill);
                fill_gnt = fill_req & (~cpu_req | rr_fill);
            end
            FILL: begin
                fill_ready = 1'b1;
            end
            default: begin
                cpu_gnt = 1'b0;
            end
        endcase
    end

    // Arbitration pointer and burst bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_fill <= 1'b1;
            cnt     <= '0;
            base    <= '0;
        end else begin
            if (contest) begin
                rr_fill <= ~rr_fill;
            end
            if (fill_acc) begin
                base <= fill_addr & ~AW'(FILL_BEATS - 1);
                cnt  <= '0;
            end else if (beat) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Bank command bus; row and data hold between transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel   <= '0;
            bank_we    <= 1'b0;
            bank_row   <= '0;
            bank_be    <= 4'h0;
            bank_wdata <= '0;
            fill_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            bank_sel  <= '0;
            bank_we   <= 1'b0;
            bank_be   <= 4'h0;
            fill_done <= 1'b0;
            busy      <= (state_nxt == FILL);
            if (cpu_xfer) begin
                bank_sel   <= onehot(cpu_addr[BW-1:0]);
                bank_row   <= cpu_addr[AW-1:BW];
                bank_we    <= cpu_we;
                bank_be    <= cpu_we ? cpu_be : 4'h0;
                bank_wdata <= cpu_wdata;
            end else if (beat) begin
                bank_sel   <= onehot(beat_addr[BW-1:0]);
                bank_row   <= beat_addr[AW-1:BW];
                bank_we    <= 1'b1;
                bank_be    <= 4'hF;
                bank_wdata <= fill_wdata;
                fill_done  <= last_beat;
            end
        end
    end

`ifdef BNK_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cpu_req && !cpu_gnt && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/bnk_sched.md
Name: bnk_sched

Overview:
- Bank-access scheduler for the banked L1 data array.
- Shares the single bank command bus between two requesters: the CPU port (single-word read/write) and the line-fill port (FILL_BEATS-word write bursts).
- Decodes the word address into a bank index plus row, and drives the per-bank select plus 4-bit byte enable that feed the per-bank BE gating.
- Sits between the cache control FSM/fill engine and the data-RAM banks.

Parameters:
- NBANKS, 4, number of data banks; power of 2, at least 2.
- AW, 16, word address width.
- DW, 32, data word width.
- FILL_BEATS, 4, words per line fill; power of 2, at most 2^AW.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU word address.
- cpu_be  in  4  CPU byte enables.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  combinational; transfer occurs when cpu_req & cpu_gnt.
- fill_req  in  1  line-fill request; held until granted.
- fill_addr  in  AW  line base word address; low log2(FILL_BEATS) bits are ignored and treated as 0.
- fill_gnt  out  1  combinational; fill burst accepted when fill_req & fill_gnt.
- fill_valid  in  1  fill beat data valid.
- fill_wdata  in  DW  fill beat data.
- fill_ready  out  1  combinational; beat consumed when fill_valid & fill_ready.
- fill_done  out  1  registered one-cycle pulse coincident with the last beat on the bank bus.
- bank_sel  out  NBANKS  registered one-hot bank select; all zero when idle.
- bank_we  out  1  registered write strobe.
- bank_row  out  AW-log2(NBANKS)  registered row address, cpu_addr or beat address >> log2(NBANKS).
- bank_be  out  4  registered byte enables; 4'hF for fill beats.
- bank_wdata  out  DW  registered write data.
- busy  out  1  registered; 1 while in FILL.

Behaviour:
- Reset: all registered outputs 0; state IDLE; beat counter 0; round-robin pointer favours fill.
- Address decode:
  - bank index = addr[log2(NBANKS)-1:0].
  - row = addr[AW-1:log2(NBANKS)].
  - bank_sel = one-hot of the bank index.
- States: IDLE, FILL.
- IDLE arbitration:
  - Only cpu_req: cpu_gnt=1.
  - Only fill_req: fill_gnt=1.
  - Both: grant the requester that lost the last contested arbitration. The pointer updates only on contested cycles.
  - cpu_gnt and fill_gnt are never both 1.
- CPU transfer:
  - Bank bus driven on the next cycle for exactly one cycle. Latency is 1.
  - bank_we = cpu_we; bank_be = cpu_be for writes, 4'h0 for reads.
  - Back-to-back CPU transfers are allowed every cycle.
- Fill accept: capture the line base and reset the beat counter to 0; go to FILL. No bank drive in the accept cycle.
- FILL state:
  - cpu_gnt=0, fill_gnt=0, fill_ready=1.
  - Each cycle with fill_valid: beat k writes address base+k on the next cycle with bank_we=1, bank_be=4'hF; counter increments.
  - fill_valid=0: no bank drive (bank_sel=0), counter holds. No timeout.
  - Beat FILL_BEATS-1 consumed: return to IDLE. fill_done pulses in the cycle that beat is on the bank bus.
  - The cycle after the last beat, IDLE arbitration runs normally. fill_done and a new CPU grant may coincide.
- Beat address: base | k, so consecutive beats rotate across banks. The counter wraps modulo FILL_BEATS and is never observed past the last beat.
- Non-transfer cycles: bank_sel=0, bank_we=0, bank_be=0. bank_wdata and bank_row hold their last values.
- Reset asserted mid-fill: burst aborts immediately; outputs return to reset values; no fill_done.

Optional Feature:
- Macro: BNK_SCHED_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0], registered, reset 0.
  - Increments in every cycle with cpu_req=1 and cpu_gnt=0.
  - Saturates at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then cpu_req write addr 0x0006, be 4'b0011, wdata 0xA5A5A5A5 -> cpu_gnt same cycle; next cycle bank_sel=4'b0100, bank_row=0x0001, bank_we=1, bank_be=4'b0011, bank_wdata=0xA5A5A5A5; following cycle bank_sel=0.
- fill_req addr 0x0043, fill_valid held 1 with data D0..D3 -> bank_sel 0001,0010,0100,1000 on consecutive cycles, rows 0x0010, bank_be=4'hF, fill_done only with D3, busy low the cycle after D3.
- cpu_req and fill_req both high from reset -> fill granted first; cpu_gnt=0 for 4 beat cycles plus the accept cycle; then cpu granted; a second contested cycle grants cpu.
- During fill, fill_valid toggles 1,0,1,0,1,1 -> exactly 4 bank writes, no bank_sel on gap cycles, fill_done on 4th write.
- Assert rst_n=0 after beat 1 of a fill -> all outputs 0 asynchronously, no fill_done; after release a CPU read is granted in 1 cycle with bank_be=0.
- BNK_SCHED_STATS_EN: cpu_req held through a full 4-beat fill -> stall_cnt=5; force 70000 stall cycles -> stall_cnt=16'hFFFF.
